// File: rtl/input_conditioner.sv
// input_conditioner: per-channel 2-flop synchroniser, debounce FSM (IDLE/PEND),
// registered clean level and one-cycle rise/fall pulses for WIDTH raw inputs.
// Optional rejected-glitch counter enabled by defining INPUT_CONDITIONER_GLITCH_CNT_EN;
// without it glitch_cnt is tied to zero.
module input_conditioner #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             stable,
  output logic [7:0]       glitch_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Per-channel "nothing pending" flags, ANDed into stable.
  logic [WIDTH-1:0] idle_ok;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  logic [WIDTH-1:0] glitch_ev;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic           s1_q, s2_q;
    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           clean_q, clean_d;
    logic           rise_q, rise_d;
    logic           fall_q, fall_d;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    logic           glitch_d;
`endif

    // Two-flop synchroniser; only s2_q is used downstream.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= raw_in[i];
        s2_q <= s1_q;
      end
    end

    // Debounce decision: count consecutive mismatches, commit or reject as a glitch.
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clean_d  = clean_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
      glitch_d = 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (s2_q != clean_q) begin
            state_d = PEND;
            cnt_d   = CNT_ONE;
          end
        end
        PEND: begin
          if (s2_q == clean_q) begin
            // Input returned before the window elapsed: reject it.
            state_d  = IDLE;
            cnt_d    = '0;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
            glitch_d = 1'b1;
`endif
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            clean_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Debounce state, clean level and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign clean_out[i]  = clean_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
    assign idle_ok[i]    = (state_q == IDLE) && (s2_q == clean_q);
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    assign glitch_ev[i]  = glitch_d;
`endif
  end

  assign stable = &idle_ok;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  logic [7:0]  glitch_q, glitch_d;
  logic [15:0] glitch_sum, glitch_tot;

  // Sum this cycle's glitch events across channels and saturate at 255.
  always_comb begin
    glitch_sum = '0;
    for (int j = 0; j < WIDTH; j++) begin
      glitch_sum = glitch_sum + 16'(glitch_ev[j]);
    end
    glitch_tot = 16'(glitch_q) + glitch_sum;
    glitch_d   = (glitch_tot > 16'd255) ? 8'd255 : glitch_tot[7:0];
  end

  // Glitch counter register; cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed testbench for input_conditioner (WIDTH=2, DEBOUNCE_CYCLES=4).
// Expected glitch counts follow INPUT_CONDITIONER_GLITCH_CNT_EN.
module tb_input_conditioner;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] raw_in;
  logic [1:0] clean_out, rise_pulse, fall_pulse;
  logic       stable;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  input_conditioner #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .stable    (stable),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance n rising edges, then settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 2'b00;
    #12;
    check("rst_clean",  32'(clean_out),  32'h0);
    check("rst_stable", 32'(stable),     32'h1);
    check("rst_glitch", 32'(glitch_cnt), 32'h0);
    reset = 1'b0;
    step(1);

    // Rise on channel 0: raw sampled at E0, commit at E5.
    raw_in = 2'b01;
    step(1);                                        // E0
    check("rise_e0_stable", 32'(stable), 32'h1);
    step(1);                                        // E1
    check("rise_e1_stable", 32'(stable), 32'h0);
    step(3);                                        // E4
    check("rise_e4_clean", 32'(clean_out),  32'h0);
    check("rise_e4_pulse", 32'(rise_pulse), 32'h0);
    step(1);                                        // E5
    check("rise_e5_clean",  32'(clean_out),  32'h1);
    check("rise_e5_pulse",  32'(rise_pulse), 32'h1);
    check("rise_e5_stable", 32'(stable),     32'h1);
    step(1);                                        // E6
    check("rise_e6_pulse", 32'(rise_pulse), 32'h0);
    check("rise_e6_clean", 32'(clean_out),  32'h1);

    // Glitch on channel 1: high for two sampling edges, then low.
    raw_in = 2'b11;
    step(2);                                        // E0, E1
    raw_in = 2'b01;
    step(1);                                        // E2: pending
    check("glitch_e2_stable", 32'(stable), 32'h0);
    for (int e = 3; e <= 7; e++) begin
      step(1);
      check($sformatf("glitch_e%0d_rise", e), 32'(rise_pulse), 32'h0);
      check($sformatf("glitch_e%0d_fall", e), 32'(fall_pulse), 32'h0);
    end
    check("glitch_clean",  32'(clean_out),  32'h1);
    check("glitch_stable", 32'(stable),     32'h1);
    check("glitch_count",  32'(glitch_cnt), GC_EN ? 32'h1 : 32'h0);

    // Bring channel 1 up so both are clean high.
    raw_in = 2'b11;
    step(6);
    check("up11_clean", 32'(clean_out),  32'h3);
    check("up11_rise",  32'(rise_pulse), 32'h2);
    step(1);

    // Simultaneous fall on both channels.
    raw_in = 2'b00;
    step(5);                                        // E0..E4
    check("fall_e4_clean", 32'(clean_out),  32'h3);
    check("fall_e4_pulse", 32'(fall_pulse), 32'h0);
    step(1);                                        // E5
    check("fall_e5_pulse",  32'(fall_pulse), 32'h3);
    check("fall_e5_clean",  32'(clean_out),  32'h0);
    check("fall_e5_stable", 32'(stable),     32'h1);
    step(1);
    check("fall_e6_pulse", 32'(fall_pulse), 32'h0);

    // Async reset with non-zero state and a pending transition.
    raw_in = 2'b11;
    step(6);
    check("arst_pre_clean", 32'(clean_out), 32'h3);
    raw_in = 2'b00;
    step(2);
    check("arst_pre_stable", 32'(stable), 32'h0);
    #2 reset = 1'b1;
    #1;                                             // still before next edge
    check("arst_clean",  32'(clean_out),  32'h0);
    check("arst_rise",   32'(rise_pulse), 32'h0);
    check("arst_fall",   32'(fall_pulse), 32'h0);
    check("arst_glitch", 32'(glitch_cnt), 32'h0);
    check("arst_stable", 32'(stable),     32'h1);
    #2 reset = 1'b0;
    step(1);

    // Reset in the middle of a pending rise; latency restarts after release.
    raw_in = 2'b01;
    step(4);                                        // E0..E3
    check("midp_pend_stable", 32'(stable), 32'h0);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    check("midp_rel_clean", 32'(clean_out), 32'h0);
    for (int e = 4; e <= 8; e++) begin              // E4 is first post-release edge
      step(1);
      check($sformatf("midp_e%0d_clean", e), 32'(clean_out),  32'h0);
      check($sformatf("midp_e%0d_rise",  e), 32'(rise_pulse), 32'h0);
    end
    step(1);                                        // E9 = E4 + 5
    check("midp_e9_clean", 32'(clean_out),  32'h1);
    check("midp_e9_rise",  32'(rise_pulse), 32'h1);
    step(1);
    check("midp_e10_rise", 32'(rise_pulse), 32'h0);

    // 300 two-cycle glitches on channel 0; counter saturates at 255.
    if (GC_EN) begin
      for (int g = 0; g < 300; g++) begin
        raw_in = 2'b00;
        step(1);
        if (g == 10) check("sat_partial", 32'(glitch_cnt), 32'd10);
        step(1);
        raw_in = 2'b01;
        step(2);
      end
      step(4);
      check("sat_count", 32'(glitch_cnt), 32'd255);
      check("sat_clean", 32'(clean_out),  32'h1);
      step(20);
      check("sat_hold",  32'(glitch_cnt), 32'd255);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
